// File: rtl/canny_seq.sv
// canny_seq: frame sequencer for a streaming Canny edge pipeline.
// Walks a free-running raster (H_LIMIT columns x V_LIMIT lines), issues a
// per-pixel pop request inside the active window, pulses a frame-start strobe
// to the datapath and latches the stage-select / threshold settings only at
// frame boundaries.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start, i_stop      begin processing / stop at next frame boundary
//   i_SW, i_seg_width    settings sampled at each frame start
//   i_fifo_empty         pixel source empty
//   o_is_new_read        one-cycle frame-start pulse (H=0, V=0)
//   o_rd_req             combinational pixel pop request
//   o_H_cursor/o_V_cursor raster position
//   o_SW, o_seg_width    settings latched for the current frame
//   o_frame_done         pulse on the last cycle of a frame
//   o_busy               combinational, high when not idle
//   o_underflow          sticky: a pixel was popped from an empty source
module canny_seq #(
   parameter int unsigned H_LIMIT  = 800,
   parameter int unsigned H_START  = 0,
   parameter int unsigned V_LIMIT  = 525,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [4:0]  i_SW,
   input  logic [3:0]  i_seg_width,
   input  logic        i_fifo_empty,
   output logic        o_is_new_read,
   output logic        o_rd_req,
   output logic [10:0] o_H_cursor,
   output logic [10:0] o_V_cursor,
   output logic [4:0]  o_SW,
   output logic [3:0]  o_seg_width,
   output logic        o_frame_done,
   output logic        o_busy,
   output logic        o_underflow
);

   localparam int unsigned CW = 11;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SYNC = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   localparam logic [CW-1:0] H_LAST = CW'(H_LIMIT - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_LIMIT - 1);

   logic [1:0]    state, state_nx;
   logic          stop_pending, stop_nx;
   logic [CW-1:0] h_nx, v_nx;
   logic          new_read_nx, done_nx, under_nx;
   logic [4:0]    sw_nx;
   logic [3:0]    seg_nx;
   logic [CW:0]   h_diff, v_diff;
   logic          h_in, v_in;

   // Active-window test via borrow bit of a widened subtraction
   assign h_diff = {1'b0, o_H_cursor} - (CW+1)'(H_START);
   assign v_diff = {1'b0, o_V_cursor} - (CW+1)'(V_ACTIVE);
   assign h_in   = ~h_diff[CW];
   assign v_in   = v_diff[CW];

   assign o_rd_req = (state == S_RUN) && h_in && v_in;
   assign o_busy   = (state != S_IDLE);

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state;
      stop_nx     = stop_pending;
      h_nx        = o_H_cursor;
      v_nx        = o_V_cursor;
      new_read_nx = 1'b0;
      sw_nx       = o_SW;
      seg_nx      = o_seg_width;
      under_nx    = o_underflow | (o_rd_req & i_fifo_empty);

      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nx = S_SYNC;
               under_nx = 1'b0;
            end
         end
         S_SYNC: begin
            if (i_stop) begin
               state_nx = S_IDLE;
            end else if (!i_fifo_empty) begin
               state_nx    = S_RUN;
               new_read_nx = 1'b1;
               sw_nx       = i_SW;
               seg_nx      = i_seg_width;
               h_nx        = '0;
               v_nx        = '0;
            end
         end
         S_RUN: begin
            if (i_stop) stop_nx = 1'b1;
            if (o_H_cursor == H_LAST) begin
               h_nx = '0;
               if (o_V_cursor == V_LAST) begin
                  // Frame end: either retire or roll straight into the next frame
                  v_nx = '0;
                  if (stop_pending) begin
                     state_nx = S_IDLE;
                     stop_nx  = 1'b0;
                  end else begin
                     new_read_nx = 1'b1;
                     sw_nx       = i_SW;
                     seg_nx      = i_seg_width;
                  end
               end else begin
                  v_nx = o_V_cursor + CW'(1);
               end
            end else begin
               h_nx = o_H_cursor + CW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Registered frame_done must be true while the cursors sit on the last pixel
      done_nx = (state_nx == S_RUN) && (h_nx == H_LAST) && (v_nx == V_LAST);
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Output and bookkeeping registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stop_pending  <= 1'b0;
         o_H_cursor    <= '0;
         o_V_cursor    <= '0;
         o_is_new_read <= 1'b0;
         o_frame_done  <= 1'b0;
         o_underflow   <= 1'b0;
         o_SW          <= 5'b00000;
         o_seg_width   <= 4'd0;
      end else begin
         stop_pending  <= stop_nx;
         o_H_cursor    <= h_nx;
         o_V_cursor    <= v_nx;
         o_is_new_read <= new_read_nx;
         o_frame_done  <= done_nx;
         o_underflow   <= under_nx;
         o_SW          <= sw_nx;
         o_seg_width   <= seg_nx;
      end
   end

endmodule

// File: doc/canny_seq.md
CANNY_SEQ -- requirements
Module: canny_seq

Interface
REQ-001 SHALL have parameter H_LIMIT, default 800: total pixel clocks per line.
REQ-002 SHALL have parameter H_START, default 0: first active column; must be less than H_LIMIT.
REQ-003 SHALL have parameter V_LIMIT, default 525: total lines per frame.
REQ-004 SHALL have parameter V_ACTIVE, default 480: number of lines carrying pixels; must be at most V_LIMIT.
REQ-005 SHALL have the following ports, in this order (name, direction, width, meaning):
- i_clk, in, 1: single clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_start, in, 1: request to begin processing frames.
- i_stop, in, 1: request to stop at the next frame boundary.
- i_SW, in, 5: stage-output select switches.
- i_seg_width, in, 4: hysteresis threshold setting.
- i_fifo_empty, in, 1: pixel source has no data.
- o_is_new_read, out, 1: one-cycle frame-start pulse to the Canny datapath.
- o_rd_req, out, 1: pop one pixel from the source this cycle.
- o_H_cursor, out, 11: current column.
- o_V_cursor, out, 11: current line.
- o_SW, out, 5: i_SW as latched at frame start.
- o_seg_width, out, 4: i_seg_width as latched at frame start.
- o_frame_done, out, 1: one-cycle pulse on the last cycle of a frame.
- o_busy, out, 1: high while the FSM is not in S_IDLE.
- o_underflow, out, 1: sticky flag, set when a pixel was read from an empty source.

Function
REQ-006 SHALL implement FSM states S_IDLE, S_SYNC, S_RUN.
REQ-007 In S_IDLE, i_start=1 SHALL move to S_SYNC and clear o_underflow; otherwise the FSM stays in S_IDLE.
REQ-008 In S_SYNC, i_stop=1 SHALL return to S_IDLE; i_stop takes priority over a simultaneous fifo-ready condition.
REQ-009 In S_SYNC with i_stop=0 and i_fifo_empty=0, the block SHALL, on the same cycle:
- pulse o_is_new_read;
- latch o_SW and o_seg_width;
- set both cursors to 0;
- move to S_RUN.
REQ-010 In S_RUN, o_H_cursor SHALL increment by 1 every cycle.
REQ-011 When o_H_cursor equals H_LIMIT-1, o_H_cursor SHALL wrap to 0 and o_V_cursor SHALL increment.
REQ-012 When o_H_cursor equals H_LIMIT-1 and o_V_cursor equals V_LIMIT-1, the block SHALL assert o_frame_done for that cycle.
REQ-013 On that frame-end cycle, both cursors SHALL wrap to 0.
REQ-014 On the frame-end cycle, if stop_pending is set, the FSM SHALL go to S_IDLE and clear stop_pending.
REQ-015 On the frame-end cycle, if stop_pending is clear, the FSM SHALL stay in S_RUN, re-latch i_SW and i_seg_width, and pulse o_is_new_read on the next cycle (H=0, V=0).
REQ-016 i_stop=1 in S_RUN SHALL set stop_pending; the current frame always completes.
REQ-017 i_start SHALL be ignored while o_busy=1.
REQ-018 o_rd_req SHALL be combinational and equal to: state is S_RUN AND o_H_cursor is at least H_START AND o_V_cursor is less than V_ACTIVE.
REQ-019 o_underflow SHALL set on any cycle where o_rd_req=1 and i_fifo_empty=1, and hold until the next accepted i_start or reset.
- Underflow SHALL NOT stall the cursors; raster timing is free-running.
REQ-020 o_SW and o_seg_width SHALL change only at the latch points in REQ-009 and REQ-015; mid-frame switch changes SHALL have no effect.
REQ-021 o_busy SHALL equal (state is not S_IDLE).
REQ-022 Cursor arithmetic SHALL be 11-bit unsigned; H_LIMIT and V_LIMIT are at most 2047.
REQ-023 All outputs except o_rd_req and o_busy SHALL be registered.

Reset
REQ-024 When i_rst_n=0, the block SHALL asynchronously set:
- state to S_IDLE;
- cursors to 0;
- stop_pending, o_is_new_read, o_frame_done and o_underflow to 0;
- o_SW to 5'b00000 and o_seg_width to 4'd0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no o_frame_done pulse.
REQ-026 After reset releases, the block SHALL wait in S_IDLE for i_start.

Verification (H_LIMIT=8, H_START=2, V_LIMIT=4, V_ACTIVE=3)
REQ-027 Start with i_fifo_empty=0:
- i_start pulse -> o_is_new_read high exactly 2 cycles later;
- o_rd_req high for H=2..7 on V=0..2 (18 pulses per frame);
- o_frame_done at H=7, V=3 (every 32 cycles).
REQ-028 Sync wait: i_fifo_empty=1 for 10 cycles after start -> the FSM stays in S_SYNC with o_is_new_read=0; the pulse appears on the first cycle i_fifo_empty=0.
REQ-029 Stop mid-frame: i_stop at H=3, V=1 -> the frame finishes; o_frame_done pulses; the next cycle o_busy=0 and o_rd_req=0.
REQ-030 Switch latch: i_SW changed from 5'b10000 to 5'b01000 mid-frame -> o_SW stays 5'b10000 until the frame boundary, then reads 5'b01000 when o_is_new_read pulses.
REQ-031 Underflow: i_fifo_empty=1 at H=4, V=0 -> o_underflow=1 sticky while the cursors keep counting; a new i_start after stop clears it.
REQ-032 Reset mid-run at H=5, V=2 -> all outputs return to reset values asynchronously; no o_frame_done pulse.
